// File: rtl/serial_borrow_subtractor_pkg.sv
// Shared definitions for the bit-serial borrow subtractor: state encoding and counter sizing.
package serial_borrow_subtractor_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned CNT_W     = $clog2(DEF_WIDTH);

  // Bit-counter width for a given operand width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_borrow_subtractor_full_subtractor.sv
// One-bit full subtractor: d = a - b - bin with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_borrow_subtractor.sv
// Bit-serial subtractor d = a - b - bin, LSB first, one bit per clock.
// Optional overflow output enabled by SERIAL_BORROW_SUBTRACTOR_OVF_EN.
module serial_borrow_subtractor
  import serial_borrow_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef SERIAL_BORROW_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             brw;
  logic             fs_d;
  logic             fs_bout;
`ifdef SERIAL_BORROW_SUBTRACTOR_OVF_EN
  logic             ovf_r;
`endif

  full_subtractor u_fs (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .bin (brw),
    .d   (fs_d),
    .bout(fs_bout)
  );

  // Control FSM and serial datapath; d/bout only update on leaving DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      brw   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      d     <= '0;
      bout  <= 1'b0;
`ifdef SERIAL_BORROW_SUBTRACTOR_OVF_EN
      ovf_r <= 1'b0;
      ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            brw   <= bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          brw  <= fs_bout;
          res  <= {fs_d, res[WIDTH-1:1]};
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            busy  <= 1'b0;
            state <= DONE;
`ifdef SERIAL_BORROW_SUBTRACTOR_OVF_EN
            ovf_r <= brw ^ fs_bout;
`endif
          end
        end
        DONE: begin
          done  <= 1'b1;
          d     <= res;
          bout  <= brw;
`ifdef SERIAL_BORROW_SUBTRACTOR_OVF_EN
          ovf   <= ovf_r;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// Randomized self-checking bench for serial_borrow_subtractor against an arithmetic reference.
module tb_serial_borrow_subtractor;

  localparam int unsigned WIDTH = 4;
  localparam int MOD  = 1 << WIDTH;
  localparam int HALF = 1 << (WIDTH - 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;
`ifdef SERIAL_BORROW_SUBTRACTOR_OVF_EN
  logic             ovf;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [WIDTH-1:0] held_d;
  logic             held_bout;
  logic             held_ovf;

  always #5 clk = ~clk;

  serial_borrow_subtractor #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .d    (d),
    .bout (bout)
`ifdef SERIAL_BORROW_SUBTRACTOR_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: unsigned difference for d/bout, signed range test for overflow.
  task automatic ref_model(input int ai, input int bi, input int bini,
                           output logic [WIDTH-1:0] rd, output logic rb, output logic ro);
    int diff, sa, sb, sd;
    diff = ai - bi - bini;
    rd   = WIDTH'(diff);
    rb   = (diff < 0);
    sa   = (ai >= HALF) ? ai - MOD : ai;
    sb   = (bi >= HALF) ? bi - MOD : bi;
    sd   = sa - sb - bini;
    ro   = (sd < -HALF) || (sd > HALF - 1);
  endtask

  task automatic check_held(input string tag);
    check({tag, ".d_held"}, 32'(d), 32'(held_d));
    check({tag, ".bout_held"}, 32'(bout), 32'(held_bout));
`ifdef SERIAL_BORROW_SUBTRACTOR_OVF_EN
    check({tag, ".ovf_held"}, 32'(ovf), 32'(held_ovf));
`endif
  endtask

  // Called just after a negedge; returns on the negedge where done is expected high.
  task automatic run_op(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi,
                        input logic bini, input bit poke, input string tag);
    logic [WIDTH-1:0] ed;
    logic             eb, eo;
    ref_model(int'(ai), int'(bi), int'(bini), ed, eb, eo);
    start = 1'b1; a = ai; b = bi; bin = bini;
    @(negedge clk);
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
    for (int k = 0; k <= int'(WIDTH) + 1; k++) begin
      check({tag, ".busy"}, 32'(busy), 32'(k < int'(WIDTH)));
      check({tag, ".done"}, 32'(done), 32'(k == int'(WIDTH) + 1));
      if (k <= int'(WIDTH)) check_held(tag);
      if (poke && (k == 1 || k == int'(WIDTH))) begin
        start = 1'b1; a = WIDTH'(1); b = WIDTH'(1); bin = 1'b0;
      end else begin
        start = 1'b0;
      end
      if (k <= int'(WIDTH)) @(negedge clk);
    end
    check({tag, ".d"}, 32'(d), 32'(ed));
    check({tag, ".bout"}, 32'(bout), 32'(eb));
`ifdef SERIAL_BORROW_SUBTRACTOR_OVF_EN
    check({tag, ".ovf"}, 32'(ovf), 32'(eo));
`endif
    held_d = ed; held_bout = eb; held_ovf = eo;
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, ".idle_done"}, 32'(done), 32'd0);
      check_held(tag);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    held_d = '0; held_bout = 1'b0; held_ovf = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check_held("rst");
    rst = 1'b0;
    @(negedge clk);

    run_op(4'd9, 4'd3, 1'b0, 1'b0, "t_9m3");
    run_op(4'd3, 4'd9, 1'b0, 1'b0, "t_3m9");
    run_op(4'd0, 4'd0, 1'b1, 1'b0, "t_0m0b");
    run_op(4'h8, 4'd1, 1'b0, 1'b0, "t_ovf1");
    run_op(4'd5, 4'd2, 1'b0, 1'b0, "t_ovf0");
    idle_cycles(2, "gap");

    // Extra start pulses during RUN and DONE must be ignored.
    run_op(4'd9, 4'd3, 1'b0, 1'b1, "t_poke");
    idle_cycles(4, "poke_hold");

    // Reset two RUN cycles into an operation aborts it.
    start = 1'b1; a = 4'd15; b = 4'd1; bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    held_d = '0; held_bout = 1'b0; held_ovf = 1'b0;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    check_held("abort");
    idle_cycles(int'(WIDTH) + 3, "abort_quiet");
    run_op(4'd15, 4'd1, 1'b0, 1'b0, "t_after_rst");

    for (int i = 0; i < 40; i++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
             ($urandom_range(0, 3) == 0), "rnd");
      if ($urandom_range(0, 1) == 1) idle_cycles(int'($urandom_range(1, 2)), "rnd_gap");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
